// File: rtl/tnn_feature_loader.sv
// Streams features into the packed classifier vector, lets it settle,
// then captures the prediction and offers it on a valid/ready port.
module tnn_feature_loader #(
  parameter int FEAT_CNT      = 11,
  parameter int FEAT_BITS     = 4,
  parameter int CLASS_CNT     = 6,
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_BITS      = 16,
  localparam int PRED_BITS    = $clog2(CLASS_CNT)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [FEAT_BITS-1:0]          in_feat,
  input  logic                          in_last,
  output logic [FEAT_CNT*FEAT_BITS-1:0] features,
  input  logic [PRED_BITS-1:0]          prediction,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [PRED_BITS-1:0]          out_class,
  output logic [CNT_BITS-1:0]           out_count,
  output logic                          frame_err
);

  localparam int IDX_W = (FEAT_CNT > 1) ? $clog2(FEAT_CNT) : 1;
  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {
    LOAD,
    SETTLE,
    OUT
  } state_e;

  state_e                        state_q, state_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [SET_W-1:0]              settle_q, settle_d;
  logic [FEAT_CNT*FEAT_BITS-1:0] feat_q, feat_d;
  logic [PRED_BITS-1:0]          class_q, class_d;
  logic [CNT_BITS-1:0]           count_q, count_d;
  logic                          err_q, err_d;
  logic                          is_last;

  // Reset gating keeps both handshakes quiet while rst_n is low.
  assign in_ready  = rst_n && (state_q == LOAD);
  assign out_valid = rst_n && (state_q == OUT);
  assign features  = feat_q;
  assign out_class = class_q;
  assign out_count = count_q;
  assign frame_err = err_q;
  assign is_last   = (idx_q == IDX_W'(FEAT_CNT - 1));

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    settle_d = settle_q;
    feat_d   = feat_q;
    class_d  = class_q;
    count_d  = count_q;
    err_d    = err_q;
    unique case (state_q)
      LOAD: begin
        if (in_valid) begin
          // First beat lands in the MSB slot.
          for (int k = 0; k < FEAT_CNT; k++) begin
            if (idx_q == IDX_W'(k)) begin
              feat_d[(FEAT_CNT-1-k)*FEAT_BITS +: FEAT_BITS] = in_feat;
            end
          end
          if (in_last != is_last) err_d = 1'b1;
          if (is_last) begin
            state_d  = SETTLE;
            idx_d    = '0;
            settle_d = SET_W'(SETTLE_CYCLES - 1);
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      SETTLE: begin
        if (settle_q == '0) begin
          class_d = prediction;
          state_d = OUT;
        end else begin
          settle_d = settle_q - SET_W'(1);
        end
      end
      OUT: begin
        if (out_ready) begin
          count_d = count_q + CNT_BITS'(1);
          state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= LOAD;
      idx_q    <= '0;
      settle_q <= '0;
      feat_q   <= '0;
      class_q  <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      settle_q <= settle_d;
      feat_q   <= feat_d;
      class_q  <= class_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_tnn_feature_loader.sv
// Directed bench for tnn_feature_loader with a stub classifier
// whose prediction is the low three bits of the vector.
module tb_tnn_feature_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_feat;
  logic        in_last;
  logic [43:0] features;
  logic [2:0]  prediction;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_class;
  logic [3:0]  out_count;
  logic        frame_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign prediction = features[2:0];

  tnn_feature_loader #(.CNT_BITS(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_feat    (in_feat),
    .in_last    (in_last),
    .features   (features),
    .prediction (prediction),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_class  (out_class),
    .out_count  (out_count),
    .frame_err  (frame_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [3:0] f, input logic last);
    in_valid = 1'b1;
    in_feat  = f;
    in_last  = last;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!out_valid && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL wait_valid out_valid=%0b required=1", out_valid);
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_feat = 4'hF;
    in_last = 1'b0; out_ready = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_ready0 got=%0b exp=0", in_ready);
    end
    step(); step();
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_hs got rdy=%0b vld=%0b exp 0 0", in_ready, out_valid);
    end
    checks++;
    if (features !== 44'h0 || out_count !== 4'd0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_state got f=%h c=%0d e=%0b exp 0 0 0",
               features, out_count, frame_err);
    end
    rst_n = 1'b1; in_valid = 1'b0;
    step();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_ready1 got=%0b exp=1", in_ready);
    end
  endtask

  task automatic test_basic();
    for (int i = 1; i <= 11; i++) send_beat(4'(i), i == 11);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_n0 got vld=%0b rdy=%0b exp 0 0", out_valid, in_ready);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_n1 got vld=%0b exp=0", out_valid);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_class !== 3'd3) begin
      errors++;
      $display("FAIL basic_n2 got vld=%0b cls=%0d exp 1 3", out_valid, out_class);
    end
    checks++;
    if (features !== 44'h123456789AB) begin
      errors++;
      $display("FAIL basic_vec got=%h exp=123456789ab", features);
    end
    handshake();
    checks++;
    if (out_count !== 4'd1 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_hs got c=%0d vld=%0b rdy=%0b exp 1 0 1",
               out_count, out_valid, in_ready);
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 11; i++) send_beat(4'(15 - i), i == 10);
    wait_valid(5);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_feat  = 4'(i);
      in_last  = i[1];
      step();
      checks++;
      if (out_valid !== 1'b1 || out_class !== 3'd5 || in_ready !== 1'b0 ||
          features !== 44'hFEDCBA98765) begin
        errors++;
        $display("FAIL bp_hold%0d got vld=%0b cls=%0d rdy=%0b f=%h exp 1 5 0 fedcba98765",
                 i, out_valid, out_class, in_ready, features);
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
    handshake();
    checks++;
    if (out_count !== 4'd2) begin
      errors++;
      $display("FAIL bp_count got=%0d exp=2", out_count);
    end
  endtask

  task automatic test_gapped();
    for (int i = 1; i <= 11; i++) begin
      int gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        in_feat = 4'($urandom);
        in_last = 1'($urandom);
        step();
      end
      send_beat(4'(i), i == 11);
    end
    wait_valid(5);
    checks++;
    if (features !== 44'h123456789AB || frame_err !== 1'b0 || out_class !== 3'd3) begin
      errors++;
      $display("FAIL gap_vec got f=%h e=%0b cls=%0d exp 123456789ab 0 3",
               features, frame_err, out_class);
    end
    handshake();
  endtask

  task automatic test_framing();
    for (int i = 0; i < 11; i++) begin
      send_beat(4'(i), i == 4 || i == 10);
      if (i == 3) begin
        checks++;
        if (frame_err !== 1'b0) begin
          errors++;
          $display("FAIL frm_pre got=%0b exp=0", frame_err);
        end
      end
      if (i == 4) begin
        checks++;
        if (frame_err !== 1'b1 || in_ready !== 1'b1) begin
          errors++;
          $display("FAIL frm_b5 got e=%0b rdy=%0b exp 1 1", frame_err, in_ready);
        end
      end
    end
    step(); step();
    checks++;
    if (out_valid !== 1'b1 || out_class !== 3'd2 || features !== 44'h0123456789A) begin
      errors++;
      $display("FAIL frm_v1 got vld=%0b cls=%0d f=%h exp 1 2 0123456789a",
               out_valid, out_class, features);
    end
    handshake();
    for (int i = 1; i <= 11; i++) send_beat(4'(i), 1'b0);
    step(); step();
    checks++;
    if (out_valid !== 1'b1 || out_class !== 3'd3 || frame_err !== 1'b1) begin
      errors++;
      $display("FAIL frm_v2 got vld=%0b cls=%0d e=%0b exp 1 3 1",
               out_valid, out_class, frame_err);
    end
    handshake();
    checks++;
    if (out_count !== 4'd5) begin
      errors++;
      $display("FAIL frm_count got=%0d exp=5", out_count);
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 11; i++) send_beat(4'(15 - i), i == 10);
    step();
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mrst_during got vld=%0b exp=0", out_valid);
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL mrst_after%0d got vld=%0b rdy=%0b exp 0 1",
                 i, out_valid, in_ready);
      end
    end
    checks++;
    if (features !== 44'h0 || out_count !== 4'd0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL mrst_state got f=%h c=%0d e=%0b exp 0 0 0",
               features, out_count, frame_err);
    end
  endtask

  task automatic test_wrap();
    for (int v = 0; v < 16; v++) begin
      for (int i = 1; i <= 11; i++) send_beat(4'(i), i == 11);
      wait_valid(5);
      handshake();
      if (v == 14) begin
        checks++;
        if (out_count !== 4'd15) begin
          errors++;
          $display("FAIL wrap_15 got=%0d exp=15", out_count);
        end
      end
    end
    checks++;
    if (out_count !== 4'd0) begin
      errors++;
      $display("FAIL wrap_0 got=%0d exp=0", out_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_gapped();
    test_framing();
    test_mid_reset();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
